avalon_sram_slave: RTL and testbench

AVALON_SRAM_SLAVE -- requirements
Module: avalon_sram_slave

---
 rtl/avalon_sram_slave.sv | 168 ++++++++++++++++
 tb/tb_avalon_sram_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_sram_slave.sv
// Avalon-style bus slave driving an asynchronous 16-bit SRAM with a fixed-latency
// SETUP / ACCESS / ACK / RECOVER strobe sequence; every output is registered.
module avalon_sram_slave #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [23:0] iAddr,
    input  logic        iRead,
    input  logic        iWrite,
    input  logic [1:0]  iBE,
    input  logic [15:0] iData,
    output logic        oACK,
    output logic [15:0] oData,
    output logic [17:0] oSRAM_ADDR,
    output logic [15:0] oSRAM_DQ,
    output logic        oSRAM_DQ_OE,
    input  logic [15:0] iSRAM_DQ,
    output logic        oSRAM_CE_N,
    output logic        oSRAM_OE_N,
    output logic        oSRAM_WE_N,
    output logic        oSRAM_UB_N,
    output logic        oSRAM_LB_N
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        ACK     = 3'd3,
        RECOVER = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d;
    logic [BE_W-1:0]     lat_be_q, lat_be_d;
    logic                lat_wr_q, lat_wr_d;

    logic                ack_d;
    logic [DATA_W-1:0]   rdata_d;
    logic [ADDR_W-1:0]   sram_addr_d;
    logic [DATA_W-1:0]   sram_dq_d;
    logic                sram_dq_oe_d;
    logic                ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;

    logic                accept_c;
    logic                unused_addr_bits;

    // Only bit 23 decodes the slave; bits 22:18 are don't-care.
    assign unused_addr_bits = ^iAddr[22:18];
    assign accept_c = ~iAddr[23] & (iRead ^ iWrite);

    // Next-state, latched request fields and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
        lat_be_d     = lat_be_q;
        lat_wr_d     = lat_wr_q;
        rdata_d      = oData;
        ack_d        = 1'b0;
        sram_addr_d  = oSRAM_ADDR;
        sram_dq_d    = oSRAM_DQ;
        sram_dq_oe_d = 1'b0;
        ce_n_d       = 1'b1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        ub_n_d       = 1'b1;
        lb_n_d       = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    lat_addr_d = iAddr[ADDR_W-1:0];
                    lat_data_d = iData;
                    lat_be_d   = iBE;
                    lat_wr_d   = iWrite;
                    cnt_d      = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                    if (!lat_wr_q) begin
                        rdata_d = {lat_be_q[1] ? iSRAM_DQ[15:8] : 8'h00,
                                   lat_be_q[0] ? iSRAM_DQ[7:0]  : 8'h00};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK:     state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pins are a function of the state being entered so they line up with it.
        if (state_d == SETUP || state_d == ACCESS || state_d == ACK) begin
            ce_n_d       = 1'b0;
            ub_n_d       = ~lat_be_d[1];
            lb_n_d       = ~lat_be_d[0];
            sram_addr_d  = lat_addr_d;
            sram_dq_oe_d = lat_wr_d;
            if (lat_wr_d) begin
                sram_dq_d = lat_data_d;
            end
            if (state_d == ACCESS) begin
                we_n_d = ~lat_wr_d;
                oe_n_d = lat_wr_d;
            end
            if (state_d == ACK) begin
                ack_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_data_q  <= '0;
            lat_be_q    <= '0;
            lat_wr_q    <= 1'b0;
            oACK        <= 1'b0;
            oData       <= '0;
            oSRAM_ADDR  <= '0;
            oSRAM_DQ    <= '0;
            oSRAM_DQ_OE <= 1'b0;
            oSRAM_CE_N  <= 1'b1;
            oSRAM_OE_N  <= 1'b1;
            oSRAM_WE_N  <= 1'b1;
            oSRAM_UB_N  <= 1'b1;
            oSRAM_LB_N  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_data_q  <= lat_data_d;
            lat_be_q    <= lat_be_d;
            lat_wr_q    <= lat_wr_d;
            oACK        <= ack_d;
            oData       <= rdata_d;
            oSRAM_ADDR  <= sram_addr_d;
            oSRAM_DQ    <= sram_dq_d;
            oSRAM_DQ_OE <= sram_dq_oe_d;
            oSRAM_CE_N  <= ce_n_d;
            oSRAM_OE_N  <= oe_n_d;
            oSRAM_WE_N  <= we_n_d;
            oSRAM_UB_N  <= ub_n_d;
            oSRAM_LB_N  <= lb_n_d;
        end
    end

endmodule

// File: tb/tb_avalon_sram_slave.sv
// Bench for avalon_sram_slave: SRAM pin model plus a transaction-level memory
// reference, directed protocol cases and randomized transfers.
module tb_avalon_sram_slave;

    localparam int unsigned WAIT = 2;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic [23:0] iAddr = '0;
    logic        iRead = 1'b0;
    logic        iWrite = 1'b0;
    logic [1:0]  iBE = '0;
    logic [15:0] iData = '0;
    logic        oACK;
    logic [15:0] oData;
    logic [17:0] oSRAM_ADDR;
    logic [15:0] oSRAM_DQ;
    logic        oSRAM_DQ_OE;
    logic [15:0] iSRAM_DQ;
    logic        oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N;

    avalon_sram_slave #(.WAIT_CYCLES(WAIT)) dut (
        .iCLK(iCLK), .iRST(iRST), .iAddr(iAddr), .iRead(iRead), .iWrite(iWrite),
        .iBE(iBE), .iData(iData), .oACK(oACK), .oData(oData),
        .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_DQ(oSRAM_DQ), .oSRAM_DQ_OE(oSRAM_DQ_OE),
        .iSRAM_DQ(iSRAM_DQ), .oSRAM_CE_N(oSRAM_CE_N), .oSRAM_OE_N(oSRAM_OE_N),
        .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_UB_N(oSRAM_UB_N), .oSRAM_LB_N(oSRAM_LB_N)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    logic [15:0] last_rd = '0;

    bit [15:0] sram    [0:262143];
    bit [15:0] ref_mem [0:262143];

    // Asynchronous SRAM pin model: byte-lane writes while CE and WE are low.
    always @(posedge iCLK) begin
        if (!oSRAM_CE_N && !oSRAM_WE_N && oSRAM_DQ_OE) begin
            if (!oSRAM_UB_N) sram[oSRAM_ADDR][15:8] <= oSRAM_DQ[15:8];
            if (!oSRAM_LB_N) sram[oSRAM_ADDR][7:0]  <= oSRAM_DQ[7:0];
        end
    end
    assign iSRAM_DQ = (!oSRAM_CE_N && !oSRAM_OE_N) ? sram[oSRAM_ADDR] : 16'hDEAD;

    always @(negedge iCLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lane_mask(input logic [1:0] be);
        return {{8{be[1]}}, {8{be[0]}}};
    endfunction

    // One transfer; the request stays on the bus (scrambled) through RECOVER.
    task automatic xfer(input bit rd, input logic [17:0] a, input logic [15:0] d,
                        input logic [1:0] be);
        int we_lo = 0, oe_lo = 0, ovl = 0, dqoe = 0, lane_bad = 0, ack_at = 0;
        logic [15:0] got = '0;
        logic [15:0] exp;
        @(negedge iCLK);
        iAddr = {6'h00, a}; iData = d; iBE = be; iRead = rd; iWrite = !rd;
        iRST = 1'b0;
        @(posedge iCLK); #1;
        iData = 16'($urandom); iBE = 2'($urandom); iAddr = {6'h00, 18'($urandom)};
        for (int n = 1; n <= 40 && ack_at == 0; n++) begin
            @(negedge iCLK);
            if (!oSRAM_WE_N) we_lo++;
            if (!oSRAM_OE_N) oe_lo++;
            if (!oSRAM_OE_N && oSRAM_DQ_OE) ovl++;
            if (oSRAM_DQ_OE) dqoe++;
            if (!oSRAM_CE_N && ({oSRAM_UB_N, oSRAM_LB_N} !== ~be || oSRAM_ADDR !== a)) lane_bad++;
            if (!rd && oSRAM_DQ_OE && oSRAM_DQ !== d) lane_bad++;
            if (oACK) begin ack_at = n; got = oData; last_ack_cyc = cyc; end
        end
        chk("ack_latency", 32'(ack_at), 32'(WAIT + 2));
        chk("we_low_cycles", 32'(we_lo), rd ? 32'd0 : 32'(WAIT));
        chk("oe_low_cycles", 32'(oe_lo), rd ? 32'(WAIT) : 32'd0);
        chk("dq_oe_cycles", 32'(dqoe), rd ? 32'd0 : 32'(WAIT + 2));
        chk("oe_dqoe_overlap", 32'(ovl), 32'd0);
        chk("latched_fields", 32'(lane_bad), 32'd0);
        if (rd) begin
            exp = ref_mem[a] & lane_mask(be);
            last_rd = exp;
            chk("read_data", 32'(got), 32'(exp));
        end else begin
            ref_mem[a] = (ref_mem[a] & ~lane_mask(be)) | (d & lane_mask(be));
            chk("odata_hold_on_write", 32'(got), 32'(last_rd));
        end
        @(negedge iCLK);
        chk("recover_pins",
            32'({oACK, oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N, oSRAM_DQ_OE}),
            32'(7'b0_11111_0));
    endtask

    task automatic bus_idle();
        iRead = 1'b0; iWrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        int t0;
        // Reset with a valid write held on the bus
        iRST = 1'b1; iWrite = 1'b1; iAddr = 24'h000200; iData = 16'h0F0F; iBE = 2'b11;
        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_pins",
            32'({oACK, oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N, oSRAM_UB_N, oSRAM_LB_N, oSRAM_DQ_OE}),
            32'(7'b0_11111_0));
        chk("reset_odata", 32'(oData), 32'h0);
        chk("reset_addr", 32'(oSRAM_ADDR), 32'h0);
        xfer(1'b0, 18'h00200, 16'h0F0F, 2'b11);
        bus_idle();

        // Basic write then read
        xfer(1'b0, 18'h00123, 16'hBEEF, 2'b11); bus_idle();
        chk("sram_word_123", 32'(sram[18'h00123]), 32'hBEEF);
        xfer(1'b1, 18'h00123, 16'h0000, 2'b11); bus_idle();
        xfer(1'b1, 18'h00200, 16'h0000, 2'b11); bus_idle();

        // Byte-lane writes, including an all-disabled write
        xfer(1'b0, 18'h00010, 16'h1234, 2'b11); bus_idle();
        xfer(1'b0, 18'h00010, 16'hAAAA, 2'b01); bus_idle();
        xfer(1'b1, 18'h00010, 16'h0000, 2'b11); bus_idle();
        chk("byte_write_12AA", 32'(last_rd), 32'h12AA);
        xfer(1'b0, 18'h00010, 16'h5555, 2'b00); bus_idle();
        xfer(1'b1, 18'h00010, 16'h0000, 2'b11); bus_idle();
        chk("be00_unchanged", 32'(last_rd), 32'h12AA);
        xfer(1'b1, 18'h00010, 16'h0000, 2'b10); bus_idle();

        // Decode and protocol rejects
        quiet = 0;
        @(negedge iCLK);
        iAddr = 24'h800010; iData = 16'hFFFF; iBE = 2'b11; iWrite = 1'b1; iRead = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (n == 10) begin iAddr = 24'h000010; iRead = 1'b1; end
            @(negedge iCLK);
            if (oACK || !oSRAM_CE_N || !oSRAM_WE_N || !oSRAM_OE_N || oSRAM_DQ_OE) quiet++;
        end
        chk("reject_activity", 32'(quiet), 32'd0);
        chk("reject_mem", 32'(sram[18'h00010]), 32'(ref_mem[18'h00010]));
        bus_idle();

        // Back-to-back with the request held one cycle past the ack
        xfer(1'b0, 18'h00033, 16'hC0DE, 2'b11);
        t0 = last_ack_cyc;
        xfer(1'b1, 18'h00033, 16'h0000, 2'b11);
        chk("b2b_ack_spacing", 32'(last_ack_cyc - t0), 32'(WAIT + 4));
        bus_idle();

        // Reset while a write is in ACCESS
        @(negedge iCLK);
        iAddr = 24'h000055; iData = 16'h5A5A; iBE = 2'b11; iWrite = 1'b1;
        quiet = 0;
        for (int n = 0; n < 10 && oSRAM_WE_N; n++) @(negedge iCLK);
        chk("reached_access", 32'(oSRAM_WE_N), 32'h0);
        iRST = 1'b1;
        @(posedge iCLK); #1;
        chk("abort_we_dqoe", 32'({oSRAM_WE_N, oSRAM_DQ_OE, oACK}), 32'(3'b100));
        bus_idle();
        @(negedge iCLK); iRST = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge iCLK);
            if (oACK) quiet++;
        end
        chk("abort_no_ack", 32'(quiet), 32'd0);
        last_rd = '0;
        xfer(1'b0, 18'h00066, 16'h6666, 2'b11); bus_idle();
        xfer(1'b1, 18'h00066, 16'h0000, 2'b11); bus_idle();

        // Randomized transfers over a small address window
        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), 18'($urandom_range(0, 7)), 16'($urandom), 2'($urandom));
            if ($urandom_range(0, 1) == 1) bus_idle();
        end
        bus_idle();
        repeat (3) @(negedge iCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
